// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: branch redirect, instruction-memory request/response and IF/ID handshake.
// The slave modport is the queue itself; the master modport is whoever drives it.
interface fetch_queue_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             flush;
  logic [PC_W-1:0]  flush_pc;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;
  logic             proto_err;

  modport slave (
    input  flush, flush_pc, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_instr, proto_err
  );

  modport master (
    output flush, flush_pc, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, proto_err
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tags responses with their PC, buffers them for IF/ID.
// Optional macro FETCHQ_BYPASS_EN forwards a response straight to the output when the queue is empty.
module fetch_queue #(
  parameter int PC_W     = 9,
  parameter int INS_W    = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [PC_W-1:0]  r_fetch_pc;
  cnt_t             r_occ, r_outst, r_drop;
  logic             r_proto_err;
  logic [PTR_W-1:0] r_q_wr, r_q_rd, r_t_wr, r_t_rd;
  logic [PC_W-1:0]  r_q_pc  [DEPTH];
  logic [INS_W-1:0] r_q_ins [DEPTH];
  logic [PC_W-1:0]  r_tag   [DEPTH];

  logic             w_issue, w_rsp_live, w_rsp_drop, w_rsp_spur;
  logic             w_byp, w_fire, w_pop, w_push;
  logic [CNT_W:0]   w_budget, w_inflight, w_drop_flush;
  logic             w_out_valid;
  logic [PC_W-1:0]  w_out_pc;
  logic [INS_W-1:0] w_out_instr;

  // Queue plus in-flight requests never exceeds DEPTH, so a response always has a slot.
  assign w_budget = {1'b0, r_occ} + {1'b0, r_outst};
  assign w_issue  = reset && !bus.flush && (w_budget < (CNT_W+1)'(DEPTH));

  assign w_rsp_drop = bus.imem_rvalid && (r_drop != '0);
  assign w_rsp_live = bus.imem_rvalid && (r_drop == '0) && (r_outst != '0);
  assign w_rsp_spur = bus.imem_rvalid && (r_drop == '0) && (r_outst == '0);

`ifdef FETCHQ_BYPASS_EN
  assign w_byp = w_rsp_live && (r_occ == '0);
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    w_out_valid = 1'b0;
    w_out_pc    = '0;
    w_out_instr = '0;
    if (r_occ != '0) begin
      w_out_valid = 1'b1;
      w_out_pc    = r_q_pc[r_q_rd];
      w_out_instr = r_q_ins[r_q_rd];
    end else if (w_byp) begin
      w_out_valid = 1'b1;
      w_out_pc    = r_tag[r_t_rd];
      w_out_instr = bus.imem_rdata;
    end
  end

  assign w_fire = w_out_valid && bus.out_ready && !bus.flush;
  assign w_pop  = w_fire && (r_occ != '0);
  assign w_push = w_rsp_live && !bus.flush && !(w_byp && bus.out_ready);

  // Everything still in flight at a redirect becomes stale, less one if it lands this very cycle.
  assign w_inflight = {1'b0, r_drop} + {1'b0, r_outst};
  always_comb begin
    w_drop_flush = w_inflight;
    if (bus.imem_rvalid && (w_inflight != '0)) w_drop_flush = w_inflight - 1'b1;
    if (w_drop_flush > (CNT_W+1)'(DEPTH))      w_drop_flush = (CNT_W+1)'(DEPTH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc  <= PC_W'(RESET_PC);
      r_occ       <= '0;
      r_outst     <= '0;
      r_drop      <= '0;
      r_proto_err <= 1'b0;
      r_q_wr      <= '0;
      r_q_rd      <= '0;
      r_t_wr      <= '0;
      r_t_rd      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the order.
      if (w_rsp_spur) r_proto_err <= 1'b1;
      if (bus.flush) begin
        r_fetch_pc <= bus.flush_pc;
        r_occ      <= '0;
        r_outst    <= '0;
        r_drop     <= w_drop_flush[CNT_W-1:0];
        r_q_wr     <= '0;
        r_q_rd     <= '0;
        r_t_wr     <= '0;
        r_t_rd     <= '0;
      end else begin
        r_occ   <= r_occ + cnt_t'(w_push) - cnt_t'(w_pop);
        r_outst <= r_outst + cnt_t'(w_issue) - cnt_t'(w_rsp_live);
        if (w_rsp_drop) r_drop <= r_drop - 1'b1;
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + PC_W'(4);
          r_t_wr     <= r_t_wr + 1'b1;
        end
        if (w_rsp_live) r_t_rd <= r_t_rd + 1'b1;
        if (w_push)     r_q_wr <= r_q_wr + 1'b1;
        if (w_pop)      r_q_rd <= r_q_rd + 1'b1;
      end
    end
  end

  // NOTE: storage arrays are not reset; counters mark them empty and the output mux zeroes stale entries.
  always_ff @(posedge clk) begin
    if (w_issue) r_tag[r_t_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_q_wr]  <= r_tag[r_t_rd];
      r_q_ins[r_q_wr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_pc;
  assign bus.out_instr = w_out_instr;
  assign bus.proto_err = r_proto_err;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model plus a PC-stream reference model.
// Honours FETCHQ_BYPASS_EN when the design is built with it.
module tb_fetch_queue;
  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;

`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
  } rsp_t;

  rsp_t pipe[$];
  int   cyc, last_due, lat_min, lat_max;
  int   n_checks, n_err;

  logic             drv_ready, drv_flush, drv_spur;
  logic [PC_W-1:0]  drv_flush_pc;

  logic [PC_W-1:0]  exp_req_pc, exp_out_pc, hold_pc;
  logic [INS_W-1:0] hold_ins;
  int               inflight;
  logic             exp_proto, prev_flush, hold_valid, spur_now;

  logic             s_req, s_valid, s_rvalid, s_proto, s_flush, s_ready;
  logic [PC_W-1:0]  s_addr, s_pc;
  logic [INS_W-1:0] s_ins;

  function automatic logic [INS_W-1:0] mem_fn(input logic [PC_W-1:0] a);
    return 32'h1357_9BDF ^ (INS_W'(a) * 32'h9E37_79B1);
  endfunction

  // One clock cycle: apply inputs, sample at negedge, check against the model, advance the model.
  task automatic step();
    rsp_t r;
    int   lat, due;
    bus.out_ready   = drv_ready;
    bus.flush       = drv_flush;
    bus.flush_pc    = drv_flush_pc;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    spur_now        = 1'b0;
    if (drv_spur) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      spur_now        = 1'b1;
      drv_spur        = 1'b0;
    end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      r = pipe.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_fn(r.addr);
    end
    @(negedge clk);
    s_req = bus.imem_req;     s_addr  = bus.imem_addr;
    s_valid = bus.out_valid;  s_pc    = bus.out_pc;     s_ins = bus.out_instr;
    s_rvalid = bus.imem_rvalid; s_proto = bus.proto_err;
    s_flush = drv_flush;      s_ready = drv_ready;

    n_checks++;
    if (s_proto !== exp_proto) begin
      n_err++; $display("FAIL proto_err @%0d: got %b expected %b", cyc, s_proto, exp_proto);
    end
    if (s_req) begin
      n_checks++;
      if (s_addr !== exp_req_pc) begin
        n_err++; $display("FAIL imem_addr @%0d: got %h expected %h", cyc, s_addr, exp_req_pc);
      end
      n_checks++;
      if (s_flush || inflight >= DEPTH) begin
        n_err++; $display("FAIL req_allowed @%0d: got req=1 expected 0 (flush=%b inflight=%0d)", cyc, s_flush, inflight);
      end
    end
    if (hold_valid) begin
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== hold_pc || s_ins !== hold_ins) begin
        n_err++; $display("FAIL stall_hold @%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                          cyc, s_valid, s_pc, s_ins, hold_pc, hold_ins);
      end
    end
    if (prev_flush) begin
      n_checks++;
      if (s_valid !== 1'b0) begin
        n_err++; $display("FAIL post_flush_valid @%0d: got %b expected 0", cyc, s_valid);
      end
    end

    if (s_flush) begin
      exp_req_pc = drv_flush_pc;
      exp_out_pc = drv_flush_pc;
      inflight   = 0;
    end else begin
      if (s_valid && s_ready) begin
        n_checks++;
        if (s_pc !== exp_out_pc || s_ins !== mem_fn(exp_out_pc)) begin
          n_err++; $display("FAIL transfer @%0d: got pc=%h ins=%h expected pc=%h ins=%h",
                            cyc, s_pc, s_ins, exp_out_pc, mem_fn(exp_out_pc));
        end
        exp_out_pc = exp_out_pc + PC_W'(4);
        inflight--;
      end
      if (s_req) begin
        exp_req_pc = exp_req_pc + PC_W'(4);
        inflight++;
      end
    end
    if (s_req) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pipe.push_back('{addr: s_addr, due: due});
    end
    if (spur_now) exp_proto = 1'b1;
    prev_flush = s_flush;
    hold_valid = s_valid && !s_ready && !s_flush;
    hold_pc    = s_pc;
    hold_ins   = s_ins;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lmin, input int lmax);
    reset = 1'b0;
    bus.flush = 1'b0; bus.flush_pc = '0; bus.out_ready = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    drv_ready = 1'b1; drv_flush = 1'b0; drv_flush_pc = '0; drv_spur = 1'b0;
    pipe.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    lat_min = lmin; lat_max = lmax;
    cyc = 0; last_due = -1;
    exp_req_pc = RESET_PC; exp_out_pc = RESET_PC; inflight = 0;
    exp_proto = 1'b0; prev_flush = 1'b0; hold_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1, 1);
    repeat (5) step();
    #2 reset = 1'b0;
    bus.imem_rvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pc !== '0 ||
        bus.out_instr !== '0 || bus.proto_err !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got req=%b v=%b pc=%h ins=%h perr=%b expected all 0",
                        bus.imem_req, bus.out_valid, bus.out_pc, bus.out_instr, bus.proto_err);
    end
    do_reset(1, 1);
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_err++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", s_req, s_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] seen[$];
    do_reset(1, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_valid && s_ready) seen.push_back(s_pc);
    end
    n_checks++;
    if (seen.size() < 3) begin
      n_err++; $display("FAIL stream_count: got %0d expected >=3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seen[i] !== PC_W'(4 * i)) begin
          n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, seen[i], PC_W'(4 * i));
        end
      end
    end
  endtask

  task automatic test_stall();
    int reqs = 0;
    do_reset(1, 1);
    drv_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req) reqs++;
    end
    n_checks++;
    if (reqs != DEPTH) begin
      n_err++; $display("FAIL stall_reqs: got %0d expected %0d", reqs, DEPTH);
    end
    n_checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== RESET_PC) begin
      n_err++; $display("FAIL stall_state: got req=%b v=%b pc=%h expected req=0 v=1 pc=%h", s_req, s_valid, s_pc, RESET_PC);
    end
    drv_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_flush();
    bit got = 1'b0;
    do_reset(3, 3);
    step();
    step();
    drv_flush = 1'b1; drv_flush_pc = 9'h040;
    step();
    drv_flush = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_valid && s_ready) begin
        got = 1'b1;
        n_checks++;
        if (s_pc !== 9'h040) begin
          n_err++; $display("FAIL flush_target: got %h expected 040", s_pc);
        end
      end
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL flush_timeout: got no transfer expected pc 040 within 20 cycles");
    end
  endtask

  task automatic test_wrap();
    do_reset(1, 1);
    step();
    drv_flush = 1'b1; drv_flush_pc = 9'h1FC;
    step();
    drv_flush = 1'b0;
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 9'h1FC) begin
      n_err++; $display("FAIL wrap_first: got req=%b addr=%h expected req=1 addr=1fc", s_req, s_addr);
    end
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 9'h000) begin
      n_err++; $display("FAIL wrap_next: got req=%b addr=%h expected req=1 addr=000", s_req, s_addr);
    end
    repeat (6) step();
  endtask

  task automatic test_spurious();
    do_reset(2, 2);
    drv_spur = 1'b1;
    step();
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_err++; $display("FAIL spurious_valid: got %b expected 0", s_valid);
    end
    step();
    n_checks++;
    if (s_proto !== 1'b1) begin
      n_err++; $display("FAIL spurious_sticky: got %b expected 1", s_proto);
    end
    repeat (8) step();
  endtask

  task automatic test_bypass();
    do_reset(1, 1);
    step();
    step();
    n_checks++;
    if (s_rvalid !== 1'b1 || s_valid !== BYP) begin
      n_err++; $display("FAIL bypass_same_cycle: got rvalid=%b v=%b expected rvalid=1 v=%b", s_rvalid, s_valid, BYP);
    end
    step();
    n_checks++;
    if (s_valid !== 1'b1) begin
      n_err++; $display("FAIL bypass_next_cycle: got v=%b expected 1", s_valid);
    end
    repeat (4) step();
  endtask

  task automatic test_random();
    do_reset(1, 3);
    for (int i = 0; i < 1500; i++) begin
      drv_ready = ($urandom_range(3, 0) != 0);
      drv_flush = ($urandom_range(39, 0) == 0);
      drv_flush_pc = PC_W'($urandom) & 9'h1FC;
      step();
    end
    drv_flush = 1'b0;
    drv_ready = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_wrap();
    test_spurious();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning program-counter width.
REQ-002 SHALL have parameter INS_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 clk  input  1  sole clock; all state rises on posedge clk.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 flush  input  1  redirect request from branch unit (PcSel).
REQ-008 flush_pc  input  PC_W  redirect target (BrPC[PC_W-1:0]).
REQ-009 imem_req  output  1  instruction-memory read request, one per cycle max.
REQ-010 imem_addr  output  PC_W  request address, valid when imem_req=1.
REQ-011 imem_rvalid  input  1  response strobe; responses return in request order, latency >=1 cycle.
REQ-012 imem_rdata  input  INS_W  response instruction, valid when imem_rvalid=1.
REQ-013 out_valid  output  1  queue head holds a valid instruction.
REQ-014 out_ready  input  1  IF/ID register accepts head (deasserted on Reg_Stall).
REQ-015 out_pc  output  PC_W  PC of head instruction.
REQ-016 out_instr  output  INS_W  head instruction.
REQ-017 proto_err  output  1  sticky flag: response received with zero outstanding requests.

Function
REQ-018 SHALL keep fetch_pc; each issued request uses imem_addr=fetch_pc, then fetch_pc+=4, wrapping modulo 2^PC_W.
REQ-019 SHALL assert imem_req only when (occupancy + outstanding) < DEPTH and flush=0; guarantees a response never overflows the queue.
REQ-020 SHALL record each issued address in an in-order tag FIFO (DEPTH entries); on non-dropped response, pushes {tag, imem_rdata} into the queue.
REQ-021 Transfer SHALL occur on posedge clk when out_valid=1 and out_ready=1; head then pops.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; push-with-pop when full SHALL not occur by REQ-019.
REQ-023 out_pc/out_instr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 On flush=1: queue and tag FIFO cleared at that edge, fetch_pc<=flush_pc, drop_cnt<=outstanding (minus 1 if a response arrives that same cycle), no request that cycle.
REQ-025 While drop_cnt>0, each imem_rvalid SHALL decrement drop_cnt and be discarded.
REQ-026 First request after flush SHALL be issued the cycle following flush, address flush_pc.
REQ-027 out_valid SHALL be 0 in the cycle after flush unless a post-flush response has been queued.
REQ-028 flush and out_ready in same cycle: flush wins; no transfer is counted as accepted.
REQ-029 imem_rvalid with outstanding=0 and drop_cnt=0 SHALL be ignored and set proto_err=1 until reset.
REQ-030 Counters SHALL be sized for 0..DEPTH inclusive.

Reset
REQ-031 While reset=0: fetch_pc=RESET_PC, occupancy=0, outstanding=0, drop_cnt=0, proto_err=0, imem_req=0, out_valid=0, out_pc=0, out_instr=0.
REQ-032 Reset SHALL act asynchronously; in-flight responses at reset SHALL be lost and must not be counted (memory is reset alongside).
REQ-033 First imem_req SHALL assert on the first posedge after reset deasserts, address RESET_PC.

Configuration
REQ-034 Macro FETCHQ_BYPASS_EN defined: when queue empty, drop_cnt=0 and imem_rvalid=1, response SHALL appear combinationally on out_valid/out_pc/out_instr same cycle; if out_ready=1 it is consumed without a push.
REQ-035 Macro undefined: every response SHALL be pushed first; minimum response-to-out_valid latency one cycle.

Verification
REQ-036 Reset release, 1-cycle memory, out_ready=1 -> imem_addr 0,4,8,...; out_pc 0,4,8 in order, out_instr matches memory.
REQ-037 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, imem_req=0 thereafter, head out_pc=0 held stable.
REQ-038 flush=1 with flush_pc=0x40 while 2 requests outstanding, 3-cycle memory -> 2 stale responses dropped; next out_pc=0x40.
REQ-039 fetch_pc=0x1FC (PC_W=9) -> next imem_addr=0x000.
REQ-040 Spurious imem_rvalid after reset with nothing outstanding -> proto_err=1, out_valid stays 0.
REQ-041 FETCHQ_BYPASS_EN defined, empty queue, response with out_ready=1 -> out_valid=1 same cycle; undefined -> out_valid one cycle later.
